// File: rtl/ppu_vga_pkg.sv
// Timing constants and framebuffer geometry shared by the PPU and the VGA
// scanout.
package ppu_vga_pkg;

    localparam int H_ACTIVE  = 640;
    localparam int H_FP      = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BP      = 48;
    localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_ACTIVE  = 480;
    localparam int V_FP      = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BP      = 33;
    localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int X_OFFSET  = 64;

    localparam int FB_WIDTH  = 256;
    localparam int FB_HEIGHT = 240;
    localparam int FB_ADDR_W = 16;
    localparam int PIC_WIDTH = 2 * FB_WIDTH;

    typedef logic [11:0]          rgb12_t;
    typedef logic [FB_ADDR_W-1:0] fb_addr_t;

    function automatic fb_addr_t fb_addr_f(input logic [7:0] row, input logic [7:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/nes_palette_rom.sv
// 2C02 palette: 6-bit palette index to 12-bit RGB (4 bits per channel).
module nes_palette_rom
    import ppu_vga_pkg::*;
(
    input  logic [5:0] idx_i,
    output rgb12_t     rgb_o
);

    // Palette lookup table
    always_comb begin
        case (idx_i)
            6'h00: rgb_o = 12'h555;  6'h01: rgb_o = 12'h017;  6'h02: rgb_o = 12'h019;  6'h03: rgb_o = 12'h308;
            6'h04: rgb_o = 12'h406;  6'h05: rgb_o = 12'h503;  6'h06: rgb_o = 12'h500;  6'h07: rgb_o = 12'h310;
            6'h08: rgb_o = 12'h220;  6'h09: rgb_o = 12'h030;  6'h0A: rgb_o = 12'h040;  6'h0B: rgb_o = 12'h030;
            6'h0C: rgb_o = 12'h033;
            6'h10: rgb_o = 12'h999;  6'h11: rgb_o = 12'h04C;  6'h12: rgb_o = 12'h33E;  6'h13: rgb_o = 12'h51E;
            6'h14: rgb_o = 12'h81B;  6'h15: rgb_o = 12'hA16;  6'h16: rgb_o = 12'h922;  6'h17: rgb_o = 12'h730;
            6'h18: rgb_o = 12'h550;  6'h19: rgb_o = 12'h270;  6'h1A: rgb_o = 12'h070;  6'h1B: rgb_o = 12'h072;
            6'h1C: rgb_o = 12'h067;
            6'h20: rgb_o = 12'hFFF;  6'h21: rgb_o = 12'h49E;  6'h22: rgb_o = 12'h77E;  6'h23: rgb_o = 12'hB6E;
            6'h24: rgb_o = 12'hE5E;  6'h25: rgb_o = 12'hE5B;  6'h26: rgb_o = 12'hE66;  6'h27: rgb_o = 12'hD82;
            6'h28: rgb_o = 12'hAA0;  6'h29: rgb_o = 12'h7C0;  6'h2A: rgb_o = 12'h4D2;  6'h2B: rgb_o = 12'h3C6;
            6'h2C: rgb_o = 12'h3BC;  6'h2D: rgb_o = 12'h333;
            6'h30: rgb_o = 12'hFFF;  6'h31: rgb_o = 12'hACE;  6'h32: rgb_o = 12'hBBE;  6'h33: rgb_o = 12'hDBE;
            6'h34: rgb_o = 12'hEAE;  6'h35: rgb_o = 12'hEAD;  6'h36: rgb_o = 12'hEBB;  6'h37: rgb_o = 12'hEC9;
            6'h38: rgb_o = 12'hCD7;  6'h39: rgb_o = 12'hBD7;  6'h3A: rgb_o = 12'hAE9;  6'h3B: rgb_o = 12'h9EB;
            6'h3C: rgb_o = 12'hADE;  6'h3D: rgb_o = 12'hAAA;
            default: rgb_o = 12'h000;
        endcase
    end

endmodule

// File: rtl/vga_scanout.sv
// 640x480@60 VGA scanout of the 256x240 NES framebuffer: pixel-doubled,
// centred, two-tick pipeline from counters to pins, vga_done handshake.
module vga_scanout
    import ppu_vga_pkg::*;
#(
    parameter int CLK_DIV     = 2,
    parameter int P_H_ACTIVE  = H_ACTIVE,
    parameter int P_H_FP      = H_FP,
    parameter int P_H_SYNC    = H_SYNC,
    parameter int P_H_BP      = H_BP,
    parameter int P_V_ACTIVE  = V_ACTIVE,
    parameter int P_V_FP      = V_FP,
    parameter int P_V_SYNC    = V_SYNC,
    parameter int P_V_BP      = V_BP,
    parameter int P_X_OFFSET  = X_OFFSET
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] fb_addr,
    input  logic [7:0]  fb_data_in,
    output logic        vga_done,
    output logic        vga_hsync,
    output logic        vga_vsync,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_blank,
    output logic        frame_start
);

    localparam int DW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC + P_H_BP - 1);
    localparam logic [9:0]    V_LAST   = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC + P_V_BP - 1);
    localparam logic [9:0]    H_ACT_L  = 10'(P_H_ACTIVE);
    localparam logic [9:0]    V_ACT_L  = 10'(P_V_ACTIVE);
    localparam logic [9:0]    V_LASTVIS = 10'(P_V_ACTIVE - 1);
    localparam logic [9:0]    HS_START = 10'(P_H_ACTIVE + P_H_FP);
    localparam logic [9:0]    HS_END   = 10'(P_H_ACTIVE + P_H_FP + P_H_SYNC);
    localparam logic [9:0]    VS_START = 10'(P_V_ACTIVE + P_V_FP);
    localparam logic [9:0]    VS_END   = 10'(P_V_ACTIVE + P_V_FP + P_V_SYNC);
    localparam logic [9:0]    X_OFF_L  = 10'(P_X_OFFSET);
    localparam logic [9:0]    X_END_L  = 10'(P_X_OFFSET + PIC_WIDTH);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d, v_q, v_d;
    logic [15:0]   fb_addr_q, fb_addr_d;
    logic          pic_d1_q, pic_d1_d, vis_d1_q, vis_d1_d;
    logic          hs_d1_q, hs_d1_d, vs_d1_q, vs_d1_d;
    rgb12_t        rgb_q, rgb_d;
    logic          blank_q, blank_d, hsync_q, hsync_d, vsync_q, vsync_d;
    logic          done_q, done_d, frame_start_q, frame_start_d;

    logic          tick_s, h_wrap_s, v_wrap_s, vis_s, pic_s;
    logic [9:0]    hx_s;
    rgb12_t        pal_rgb_s;
    logic          unused_bits_s;

    nes_palette_rom u_pal (
        .idx_i (fb_data_in[5:0]),
        .rgb_o (pal_rgb_s)
    );

    assign tick_s        = (div_q == DIV_MAX);
    assign h_wrap_s      = (h_q == H_LAST);
    assign v_wrap_s      = (v_q == V_LAST);
    assign vis_s         = (h_q < H_ACT_L) && (v_q < V_ACT_L);
    assign pic_s         = vis_s && (h_q >= X_OFF_L) && (h_q < X_END_L);
    assign hx_s          = h_q - X_OFF_L;
    assign unused_bits_s = &{1'b0, fb_data_in[7:6], hx_s[9], hx_s[0]};

    // Next-state: divider, raster counters, both pipeline stages, handshake
    always_comb begin
        div_d         = tick_s ? {DW{1'b0}} : div_q + {{(DW-1){1'b0}}, 1'b1};
        h_d           = h_q;
        v_d           = v_q;
        fb_addr_d     = fb_addr_q;
        pic_d1_d      = pic_d1_q;
        vis_d1_d      = vis_d1_q;
        hs_d1_d       = hs_d1_q;
        vs_d1_d       = vs_d1_q;
        rgb_d         = rgb_q;
        blank_d       = blank_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        done_d        = done_q;
        frame_start_d = 1'b0;
        if (tick_s) begin
            h_d = h_wrap_s ? 10'd0 : h_q + 10'd1;
            if (h_wrap_s) begin
                v_d = v_wrap_s ? 10'd0 : v_q + 10'd1;
            end else begin
                v_d = v_q;
            end
            // Address frozen outside the picture so the PPU side never sees a read move
            fb_addr_d     = pic_s ? fb_addr_f(v_q[8:1], hx_s[8:1]) : fb_addr_q;
            pic_d1_d      = pic_s;
            vis_d1_d      = vis_s;
            hs_d1_d       = ~((h_q >= HS_START) && (h_q < HS_END));
            vs_d1_d       = ~((v_q >= VS_START) && (v_q < VS_END));
            rgb_d         = pic_d1_q ? pal_rgb_s : 12'h000;
            blank_d       = ~vis_d1_q;
            hsync_d       = hs_d1_q;
            vsync_d       = vs_d1_q;
            frame_start_d = (h_q == 10'd0) && (v_q == 10'd0);
            if (h_wrap_s && (v_q == V_LASTVIS)) begin
                done_d = 1'b1;
            end else if (h_wrap_s && v_wrap_s) begin
                done_d = 1'b0;
            end else begin
                done_d = done_q;
            end
        end else begin
            frame_start_d = 1'b0;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q         <= {DW{1'b0}};
            h_q           <= 10'd0;
            v_q           <= 10'd0;
            fb_addr_q     <= 16'h0000;
            pic_d1_q      <= 1'b0;
            vis_d1_q      <= 1'b0;
            hs_d1_q       <= 1'b1;
            vs_d1_q       <= 1'b1;
            rgb_q         <= 12'h000;
            blank_q       <= 1'b1;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            done_q        <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            h_q           <= h_d;
            v_q           <= v_d;
            fb_addr_q     <= fb_addr_d;
            pic_d1_q      <= pic_d1_d;
            vis_d1_q      <= vis_d1_d;
            hs_d1_q       <= hs_d1_d;
            vs_d1_q       <= vs_d1_d;
            rgb_q         <= rgb_d;
            blank_q       <= blank_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            done_q        <= done_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign fb_addr     = fb_addr_q;
    assign vga_done    = done_q;
    assign vga_hsync   = hsync_q;
    assign vga_vsync   = vsync_q;
    assign vga_r       = rgb_q[11:8];
    assign vga_g       = rgb_q[7:4];
    assign vga_b       = rgb_q[3:0];
    assign vga_blank   = blank_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench: a full-timing instance for horizontal/address/pixel checks
// and a short-frame instance for vertical timing and the vga_done handshake.
module tb_vga_scanout;

    logic        clk = 1'b0;
    logic        rst0, rst1;
    logic [7:0]  fb0, fb1;
    logic [15:0] addr0, addr1;
    logic        done0, done1, hs0, hs1, vs0, vs1, blank0, blank1, fs0, fs1;
    logic [3:0]  r0, g0, b0, r1, g1, b1;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    vga_scanout u0 (
        .clk(clk), .rst(rst0), .fb_addr(addr0), .fb_data_in(fb0), .vga_done(done0),
        .vga_hsync(hs0), .vga_vsync(vs0), .vga_r(r0), .vga_g(g0), .vga_b(b0),
        .vga_blank(blank0), .frame_start(fs0)
    );

    vga_scanout #(.P_V_ACTIVE(4), .P_V_FP(2), .P_V_SYNC(2), .P_V_BP(2)) u1 (
        .clk(clk), .rst(rst1), .fb_addr(addr1), .fb_data_in(fb1), .vga_done(done1),
        .vga_hsync(hs1), .vga_vsync(vs1), .vga_r(r1), .vga_g(g1), .vga_b(b1),
        .vga_blank(blank1), .frame_start(fs1)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after clock edge number k (edge 0 = last reset edge)
    task automatic adv(input int k);
        while (cyc < k) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; fb0 = 8'h30; fb1 = 8'h30;
        repeat (3) @(posedge clk);
        #1; rst0 = 1'b0; cyc = 0;

        chk("rst_hsync", {15'd0, hs0}, 16'd1);
        chk("rst_vsync", {15'd0, vs0}, 16'd1);
        chk("rst_blank", {15'd0, blank0}, 16'd1);
        chk("rst_rgb", {4'd0, r0, g0, b0}, 16'h0000);
        chk("rst_done", {15'd0, done0}, 16'd0);
        chk("rst_fs", {15'd0, fs0}, 16'd0);
        adv(1);    chk("fs_c1", {15'd0, fs0}, 16'd0);
        adv(2);    chk("fs_c2", {15'd0, fs0}, 16'd1);
        adv(3);    chk("fs_c3", {15'd0, fs0}, 16'd0);
        adv(130);  chk("addr_64_0", addr0, 16'h0000);
                   chk("border_63_rgb", {4'd0, r0, g0, b0}, 16'h0000);
                   chk("border_63_blank", {15'd0, blank0}, 16'd0);
        adv(132);  chk("addr_65_0", addr0, 16'h0000);
                   chk("pix_64_white", {4'd0, r0, g0, b0}, 16'h0FFF);
        adv(134);  chk("addr_66_0", addr0, 16'h0001);
        adv(1152); chk("addr_575_0", addr0, 16'h00FF);
        adv(1154); chk("pix_575_white", {4'd0, r0, g0, b0}, 16'h0FFF);
        adv(1156); chk("border_576_rgb", {4'd0, r0, g0, b0}, 16'h0000);
                   chk("border_576_blank", {15'd0, blank0}, 16'd0);
        adv(1282); chk("blank_639", {15'd0, blank0}, 16'd0);
        adv(1284); chk("blank_640", {15'd0, blank0}, 16'd1);
        adv(1314); chk("hsync_655", {15'd0, hs0}, 16'd1);
        adv(1316); chk("hsync_656", {15'd0, hs0}, 16'd0);
        adv(1506); chk("hsync_751", {15'd0, hs0}, 16'd0);
        adv(1508); chk("hsync_752", {15'd0, hs0}, 16'd1);
        fb0 = 8'h0F;
        adv(1804); chk("pix_0f_black", {4'd0, r0, g0, b0}, 16'h0000);
                   chk("pix_0f_blank", {15'd0, blank0}, 16'd0);
        fb0 = 8'h21;
        adv(3334); chk("addr_66_2", addr0, 16'h0101);
        adv(3404); chk("pix_21", {4'd0, r0, g0, b0}, 16'h049E);
        adv(4934); chk("addr_66_3", addr0, 16'h0101);
        fb0 = 8'hE1;
        adv(6200); chk("hsync_698_3", {15'd0, hs0}, 16'd0);

        rst0 = 1'b1;
        @(posedge clk);
        #1; rst0 = 1'b0; cyc = 0;
        chk("mid_rst_hsync", {15'd0, hs0}, 16'd1);
        chk("mid_rst_vsync", {15'd0, vs0}, 16'd1);
        chk("mid_rst_blank", {15'd0, blank0}, 16'd1);
        chk("mid_rst_rgb", {4'd0, r0, g0, b0}, 16'h0000);
        chk("mid_rst_done", {15'd0, done0}, 16'd0);
        chk("mid_rst_addr", addr0, 16'h0000);
        adv(2);    chk("mid_rst_fs", {15'd0, fs0}, 16'd1);
        adv(134);  chk("mid_rst_addr66", addr0, 16'h0001);
        adv(136);  chk("mid_rst_pix66", {4'd0, r0, g0, b0}, 16'h049E);
                   chk("mid_rst_blank66", {15'd0, blank0}, 16'd0);

        rst1 = 1'b0; cyc = 0;
        adv(3330);  chk("s_addr_64_2", addr1, 16'h0100);
        adv(4930);  chk("s_addr_64_3", addr1, 16'h0100);
        adv(6399);  chk("s_done_pre", {15'd0, done1}, 16'd0);
        adv(6400);  chk("s_done_rise", {15'd0, done1}, 16'd1);
                    chk("s_addr_hold_a", addr1, 16'h01FF);
        adv(6604);  chk("s_vblank_blank", {15'd0, blank1}, 16'd1);
                    chk("s_vblank_rgb", {4'd0, r1, g1, b1}, 16'h0000);
        adv(9602);  chk("s_vsync_5", {15'd0, vs1}, 16'd1);
        adv(9604);  chk("s_vsync_6", {15'd0, vs1}, 16'd0);
        adv(12802); chk("s_vsync_7", {15'd0, vs1}, 16'd0);
        adv(12804); chk("s_vsync_8", {15'd0, vs1}, 16'd1);
        adv(15998); chk("s_addr_hold_b", addr1, 16'h01FF);
        adv(15999); chk("s_done_high", {15'd0, done1}, 16'd1);
        adv(16000); chk("s_done_fall", {15'd0, done1}, 16'd0);
        adv(16001); chk("s_fs_pre", {15'd0, fs1}, 16'd0);
        adv(16002); chk("s_fs_pulse", {15'd0, fs1}, 16'd1);
        adv(16003); chk("s_fs_post", {15'd0, fs1}, 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_scanout.md
Name: vga_scanout

Overview:
Reader end of the PPU→VGA framebuffer interface. It generates 640x480@60 VGA timing and reads the 256x240 framebuffer that the PPU writes. Each NES pixel is doubled in both axes and centred with 64-pixel black side borders. Each 6-bit palette index is mapped to 12-bit RGB. It drives vga_done, which tells the PPU render FSM when the framebuffer is free to overwrite.

Parameters:
CLK_DIV, 2, clk cycles per pixel tick; must be >=2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch
H_SYNC, 96, hsync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch
V_SYNC, 2, vsync width
V_BP, 33, vertical back porch
X_OFFSET, 64, left border width in VGA pixels

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
fb_addr  out  16  framebuffer read address = {nes_row[7:0], nes_col[7:0]}
fb_data_in  in  8  framebuffer read data; synchronous RAM, valid 1 clk after fb_addr
vga_done  out  1  high = scanout not reading the framebuffer, so the PPU may render
vga_hsync  out  1  horizontal sync, active-low
vga_vsync  out  1  vertical sync, active-low
vga_r  out  4  red
vga_g  out  4  green
vga_b  out  4  blue
vga_blank  out  1  high outside the visible 640x480 area
frame_start  out  1  one-clk pulse at the first pixel tick of line 0, pixel 0

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: div counter 0, h=0, v=0, fb_addr=0, vga_done=0, hsync=1, vsync=1, RGB=0, vga_blank=1, frame_start=0.
- Pixel tick: asserted when the divider counter equals CLK_DIV-1; the counter then wraps to 0. All counters and pipeline stages advance only on a tick.
- Horizontal counter h: 0..H_TOTAL-1 (800), wraps to 0.
- Vertical counter v: increments when h wraps; range 0..V_TOTAL-1 (525), wraps to 0.
- Visible area: vis = (h<640) && (v<480).
- Picture area: pic = vis && h>=X_OFFSET && h<X_OFFSET+512.
- Sync, from raw counters:
  - hsync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), i.e. 656..751.
  - vsync low for v in [490, 492).
- Stage 1 (tick after counters): register
  - fb_addr = {v[8:1], (h-X_OFFSET)[8:1]};
  - delayed copies of pic, vis, hsync and vsync.
  - fb_addr is held at its last value outside the picture area; that value is don't-care but must stay in range.
- Stage 2 (next tick): register
  - RGB = pic_d1 ? palette(fb_data_in[5:0]) : 0;
  - vga_blank = ~vis_d1;
  - hsync and vsync from stage 1.
- Latency: 2 pixel ticks from counter to pins, with all outputs aligned. fb_data_in bits 7:6 are ignored.
- vga_done:
  - set at the tick where v becomes 480 and h = 0;
  - cleared at the tick where v wraps to 0.
  - Guarantees no fb read while it is high.
  - The PPU sees the high→low edge as "scanout started".
- frame_start: one clk pulse on the tick where h=0, v=0. It also fires after reset, on the first tick.
- Reset mid-frame: everything restarts at h=0, v=0 with vga_done=0. No partial sync pulse is held.
- Width rule: h-X_OFFSET is computed in 10 bits; only bits [8:1] are used when pic.

Decomposition:
- Shared package ppu_vga_pkg: timing constants (H/V totals, porch and sync widths, X_OFFSET) and the framebuffer geometry (256x240, 16-bit address format).
- Sub-module nes_palette_rom: combinational 64-entry, 6-bit index → 12-bit RGB, using the standard 2C02 palette reduced to 4 bits per channel.
- Top module: divider, counters, two-stage pipeline, vga_done.

Test Plan:
- Timing: reset, run 2 frames with CLK_DIV=2 → hsync low 96 ticks every 800 ticks; vsync low exactly 2 lines every 525 lines; frame_start period 840000 clk.
- Address mapping: h=64,v=0 → fb_addr=0x0000; h=575,v=479 → fb_addr=0xEFFF; h=66,v=3 → fb_addr=0x0101. Each NES pixel address is held for 2 ticks and repeated for 2 lines.
- Pixel data: fb returns 0x0F at every address → RGB=0; fb returns 0x30 → RGB equals palette entry 0x30 (white) on picture pixels. Border pixels h<64 or h>=576 → RGB=0 with vga_blank=0.
- Blanking and alignment: vga_blank rises exactly 2 ticks after h reaches 640. RGB is 0 whenever vga_blank=1, including during the whole of v 480..524.
- vga_done: rises on the tick v becomes 480 and falls on the tick v wraps to 0. No change in fb_addr is observed while vga_done=1.
- Reset: assert rst at h=300, v=200 for 1 clk → next clk h=0, v=0, vga_done=0, hsync=vsync=1, RGB=0, vga_blank=1.
